// File: rtl/video_scheduler.sv
// video_scheduler: raster timing (divider, h/v counters, sync/blank/strobes)
// plus a per-line sprite prefetch engine sharing one single-port memory with
// a host write port. Fetched words land in a shadow buffer and are committed
// to line_data at the start of the visible line.
// Optional build macro: VIDEO_SCHED_FRAME_IRQ_EN adds irq_ack / frame_irq.
module video_scheduler #(
    parameter int H_RES       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_RES       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int PIX_DIV     = 2,
    parameter int SYNC_POL    = 0,
    parameter int FETCH_WORDS = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    localparam int H_TOTAL    = H_RES + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL    = V_RES + V_FP + V_SYNC + V_BP,
    localparam int HW         = $clog2(H_TOTAL) + 1,
    localparam int VW         = $clog2(V_TOTAL) + 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
`ifdef VIDEO_SCHED_FRAME_IRQ_EN
    input  logic                          irq_ack,
    output logic                          frame_irq,
`endif
    output logic signed [HW-1:0]          hcount,
    output logic signed [VW-1:0]          vcount,
    output logic                          pix_en,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          blank,
    output logic                          line_end,
    output logic                          frame_start,
    output logic [FETCH_WORDS*DATA_W-1:0] line_data,
    output logic                          fetch_err,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_re,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic [ADDR_W-1:0]             host_addr,
    input  logic [DATA_W-1:0]             host_data
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int IDX_W = (FETCH_WORDS > 1) ? $clog2(FETCH_WORDS) : 1;

    localparam logic signed [HW-1:0] HRST   = HW'(-(H_FP + H_SYNC + H_BP));
    localparam logic signed [HW-1:0] H_LAST = HW'(H_RES - 1);
    localparam logic signed [HW-1:0] HS_BEG = HW'(-(H_SYNC + H_BP));
    localparam logic signed [HW-1:0] HS_END = HW'(-H_BP);
    localparam logic signed [HW-1:0] H_CMT  = HW'(-1);
    localparam logic signed [VW-1:0] VRST   = VW'(-(V_FP + V_SYNC + V_BP));
    localparam logic signed [VW-1:0] V_LAST = VW'(V_RES - 1);
    localparam logic signed [VW-1:0] VS_BEG = VW'(-(V_SYNC + V_BP));
    localparam logic signed [VW-1:0] VS_END = VW'(-V_BP);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FETCH_WORDS - 1);
    localparam logic             SYNC_ACT = (SYNC_POL != 0);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_LAST, S_READY} state_t;

    state_t                                r_state, w_state_nxt;
    logic [DIV_W-1:0]                      r_div;
    logic signed [HW-1:0]                  r_hcount;
    logic signed [VW-1:0]                  r_vcount, w_vcount_nxt;
    logic [IDX_W-1:0]                      r_idx;
    logic [FETCH_WORDS-1:0][DATA_W-1:0]    r_shadow, r_line;
    logic                                  r_err;
    logic                                  w_pix_en, w_line_end, w_frame_start;
    logic                                  w_fetch_go, w_commit;
    logic [ADDR_W-1:0]                     w_rd_addr;

    assign w_pix_en      = (r_div == DIV_LAST);
    assign w_line_end    = w_pix_en && (r_hcount == H_LAST);
    assign w_frame_start = w_line_end && (r_vcount == V_LAST);
    assign w_vcount_nxt  = !w_line_end    ? r_vcount :
                           w_frame_start  ? VRST     : r_vcount + VW'(1);
    // Fetch only for lines that will be visible once the counter advances
    assign w_fetch_go    = w_line_end && !w_vcount_nxt[VW-1] && (w_vcount_nxt <= V_LAST);
    // Commit point: last blanking pixel before the visible part of the line
    assign w_commit      = w_pix_en && (r_hcount == H_CMT);
    assign w_rd_addr     = ADDR_W'(32'(r_vcount) * FETCH_WORDS + 32'(r_idx));

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign pix_en      = w_pix_en;
    assign line_end    = w_line_end;
    assign frame_start = w_frame_start;
    assign hsync       = ((r_hcount >= HS_BEG) && (r_hcount < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
    assign vsync       = ((r_vcount >= VS_BEG) && (r_vcount < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
    assign blank       = r_hcount[HW-1] | r_vcount[VW-1];
    assign line_data   = r_line;
    assign fetch_err   = r_err;

    // Pixel-enable divider: wraps at PIX_DIV-1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_div <= '0;
        else if (w_pix_en) r_div <= '0;
        else               r_div <= r_div + DIV_W'(1);
    end

    // Raster counters: hcount per pixel, vcount per line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount <= HRST;
            r_vcount <= VRST;
        end else begin
            if (w_pix_en) r_hcount <= w_line_end ? HRST : r_hcount + HW'(1);
            r_vcount <= w_vcount_nxt;
        end
    end

    // Fetch FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Fetch FSM next state and memory arbitration (fetch always has priority)
    always_comb begin
        w_state_nxt = r_state;
        mem_re      = 1'b0;
        host_ready  = (r_state != S_READ);
        case (r_state)
            S_IDLE:  if (w_fetch_go) w_state_nxt = S_READ;
            S_READ: begin
                mem_re = 1'b1;
                if (r_idx == IDX_LAST) w_state_nxt = S_LAST;
            end
            S_LAST:  w_state_nxt = S_READY;
            S_READY: if (w_commit) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // host_ready idles high in reset, so the write strobe is gated here
        mem_we    = reset_n && host_valid && host_ready;
        mem_addr  = mem_re ? w_rd_addr : (mem_we ? host_addr : '0);
        mem_wdata = mem_we ? host_data : '0;
    end

    // Word index, shadow capture (data arrives one clk after mem_re), commit, error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx    <= '0;
            r_shadow <= '0;
            r_line   <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_idx <= '0;
                S_READ: begin
                    if (r_idx != '0) r_shadow[r_idx - IDX_W'(1)] <= mem_rdata;
                    r_idx <= r_idx + IDX_W'(1);
                end
                S_LAST:  r_shadow[FETCH_WORDS-1] <= mem_rdata;
                S_READY: if (w_commit) r_line <= r_shadow;
                default: ;
            endcase
            // A late fetch leaves line_data alone and commits at the next commit point
            if (w_commit && (r_state == S_READ || r_state == S_LAST)) r_err <= 1'b1;
        end
    end

`ifdef VIDEO_SCHED_FRAME_IRQ_EN
    logic r_frame_irq;
    assign frame_irq = r_frame_irq;

    // Frame interrupt: set on frame_start, cleared by ack, set wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           r_frame_irq <= 1'b0;
        else if (w_frame_start) r_frame_irq <= 1'b1;
        else if (irq_ack)       r_frame_irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_video_scheduler.sv
// tb_video_scheduler: directed bench with a scoreboard for memory reads, host
// writes and committed line data. Horizontal timing is the default 800-pixel
// line; vertical timing is shortened (6 visible lines, VRST = -7) so a full
// frame fits the cycle budget.
module tb_video_scheduler;

    localparam int TB_VRES = 6, TB_VFP = 2, TB_VSYNC = 2, TB_VBP = 3;
    localparam int TB_VTOT = TB_VRES + TB_VFP + TB_VSYNC + TB_VBP;
    localparam int TB_VRST = -(TB_VFP + TB_VSYNC + TB_VBP);
    localparam int TB_HW   = $clog2(800) + 1;
    localparam int TB_VW   = $clog2(TB_VTOT) + 1;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic signed [TB_HW-1:0]  hcount;
    logic signed [TB_VW-1:0]  vcount;
    logic                     pix_en, hsync, vsync, blank, line_end, frame_start;
    logic [63:0]              line_data;
    logic                     fetch_err;
    logic [7:0]               mem_addr;
    logic                     mem_re, mem_we;
    logic [15:0]              mem_wdata;
    logic [15:0]              mem_rdata = 16'hDEAD;
    logic                     host_valid = 1'b0;
    logic                     host_ready;
    logic [7:0]               host_addr = '0;
    logic [15:0]              host_data = '0;
`ifdef VIDEO_SCHED_FRAME_IRQ_EN
    logic                     irq_ack = 1'b0;
    logic                     frame_irq;
`endif

    int n_asrt = 0;
    int n_fail = 0;

    logic [7:0]   rd_q[$];
    logic [23:0]  wr_q[$];
    logic [63:0]  ln_q[$];
    int           mdl_v = TB_VRST;
    logic [63:0]  last_line = '0;
    int           prev_h = -160;
    logic         both_seen = 1'b0;

    video_scheduler #(
        .V_RES(TB_VRES), .V_FP(TB_VFP), .V_SYNC(TB_VSYNC), .V_BP(TB_VBP)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
`ifdef VIDEO_SCHED_FRAME_IRQ_EN
        .irq_ack(irq_ack), .frame_irq(frame_irq),
`endif
        .hcount(hcount), .vcount(vcount), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .blank(blank), .line_end(line_end), .frame_start(frame_start),
        .line_data(line_data), .fetch_err(fetch_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data)
    );

    always #5 clk = ~clk;

    // Memory model: read data is addr+0x100 one clk after mem_re, junk otherwise
    always @(posedge clk) mem_rdata <= mem_re ? (16'h0100 + {8'h00, mem_addr}) : 16'hDEAD;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0: return line_end;
            1: return frame_start;
            2: return hsync;
            3: return vsync;
            4: return mem_re;
            5: return host_ready;
            6: return (hcount == 0);
            default: return 1'b0;
        endcase
    endfunction

    // Wait (bounded) until probe(sel)==want, sampling on negedges
    task automatic wait_for(input string tag, input int sel, input logic want, input int budget, output int n);
        n = 0;
        while (probe(sel) !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reached"}, probe(sel), want);
    endtask

    // Scoreboard: producer on line_end, consumers on mem_re / mem_we / commit
    always @(negedge clk) begin
        if (!reset_n) begin
            rd_q.delete();
            ln_q.delete();
            mdl_v     = TB_VRST;
            last_line = '0;
            prev_h    = -160;
        end else begin
            if (mem_re && mem_we) both_seen = 1'b1;
            if (mem_re) begin
                if (rd_q.size() == 0) chk("rd_pending", rd_q.size(), 1);
                else chk("rd_addr", mem_addr, rd_q.pop_front());
            end
            if (mem_we) begin
                if (wr_q.size() == 0) chk("wr_pending", wr_q.size(), 1);
                else begin
                    logic [23:0] e;
                    e = wr_q.pop_front();
                    chk("wr_addr", mem_addr, e[23:16]);
                    chk("wr_data", mem_wdata, e[15:0]);
                end
            end
            if (prev_h == -1 && hcount == 0) begin
                if (ln_q.size() != 0) last_line = ln_q.pop_front();
                chk("line_data", line_data, last_line);
            end
            if (line_end) begin
                chk("le_vcount", vcount, mdl_v);
                chk("le_hcount", hcount, 639);
                chk("frame_start", frame_start, mdl_v == TB_VRES - 1);
                mdl_v = (mdl_v == TB_VRES - 1) ? TB_VRST : mdl_v + 1;
                if (mdl_v >= 0) begin
                    logic [63:0] v;
                    v = '0;
                    for (int k = 0; k < 4; k++) begin
                        rd_q.push_back(8'(mdl_v * 4 + k));
                        v[k*16 +: 16] = 16'h0100 + 16'(8'(mdl_v * 4 + k));
                    end
                    ln_q.push_back(v);
                end
            end else if (frame_start) begin
                chk("frame_start_stray", frame_start, 0);
            end
            prev_h = hcount;
        end
    end

    initial begin
        int n;
        // Reset state, with a host request pending that must not reach memory
        host_valid = 1'b1; host_addr = 8'h12; host_data = 16'h3456;
        repeat (3) @(negedge clk);
        chk("rst_hcount", hcount, -160);
        chk("rst_vcount", vcount, TB_VRST);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_blank", blank, 1);
        chk("rst_host_ready", host_ready, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_line_data", line_data, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_pix_en", pix_en, 0);
        host_valid = 1'b0; host_addr = '0; host_data = '0;
        @(negedge clk); reset_n = 1'b1;

        // First pixel strobe
        @(negedge clk);
        chk("pe1_pix_en", pix_en, 1);
        chk("pe1_hcount", hcount, -160);
        @(negedge clk);
        chk("pe2_pix_en", pix_en, 0);
        chk("pe2_hcount", hcount, -159);

        // Horizontal sync window and line period
        wait_for("hs_fall", 2, 1'b0, 100, n);
        chk("hs_fall_hcount", hcount, -144);
        wait_for("hs_rise", 2, 1'b1, 300, n);
        chk("hs_low_clks", n, 192);
        chk("hs_rise_hcount", hcount, -48);
        wait_for("le_a", 0, 1'b1, 2000, n);
        @(negedge clk);
        wait_for("le_b", 0, 1'b1, 2000, n);
        chk("line_period", n + 1, 1600);

        // Vertical sync window
        wait_for("vs_fall", 3, 1'b0, 3500, n);
        chk("vs_fall_vcount", vcount, -5);
        wait_for("vs_rise", 3, 1'b1, 3500, n);
        chk("vs_low_clks", n, 3200);
        chk("vs_rise_vcount", vcount, -3);

        // Reach the line_end that enters visible line 0
        for (int k = 0; k < 4; k++) begin
            wait_for("le_pre0", 0, 1'b1, 2000, n);
            if (vcount == -1) break;
            @(negedge clk);
        end
        chk("pre0_vcount", vcount, -1);
        chk("pre0_blank", blank, 1);

        // Host request held across the line-0 fetch
        @(posedge clk); #1;
        host_valid = 1'b1; host_addr = 8'h55; host_data = 16'hBEEF;
        wr_q.push_back({8'h55, 16'hBEEF});
        @(negedge clk);
        chk("f0_mem_re", mem_re, 1);
        chk("f0_mem_addr", mem_addr, 0);
        chk("f0_mem_we", mem_we, 0);
        n = 0;
        while (!host_ready && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("hr_low_clks", n, 4);
        chk("hw_mem_we", mem_we, 1);
        chk("hw_mem_re", mem_re, 0);
        chk("hw_mem_addr", mem_addr, 8'h55);
        chk("hw_mem_wdata", mem_wdata, 16'hBEEF);
        @(posedge clk); #1;
        host_valid = 1'b0; host_addr = '0; host_data = '0;
        @(negedge clk);
        chk("hw_done_mem_we", mem_we, 0);

        // Line 0 commit
        wait_for("h0_line0", 6, 1'b1, 2000, n);
        chk("l0_blank", blank, 0);
        chk("l0_line_data", line_data, 64'h0103_0102_0101_0100);
        chk("l0_fetch_err", fetch_err, 0);

        // Line 1 fetch addresses start at 4
        wait_for("le_l0", 0, 1'b1, 2000, n);
        @(negedge clk);
        wait_for("f1_re", 4, 1'b1, 10, n);
        chk("f1_mem_addr", mem_addr, 4);
        chk("f1_vcount", vcount, 1);

        // Frame period
        wait_for("fs_a", 1, 1'b1, 10000, n);
        chk("fs_vcount", vcount, TB_VRES - 1);
        @(negedge clk);
        wait_for("fs_b", 1, 1'b1, 22000, n);
        chk("frame_period", n + 1, 1600 * TB_VTOT);

        // Reset in the middle of a fetch
        wait_for("fr_re", 4, 1'b1, 13000, n);
        chk("fr_vcount", vcount, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("mr_mem_re", mem_re, 0);
        chk("mr_line_data", line_data, 0);
        chk("mr_fetch_err", fetch_err, 0);
        chk("mr_hcount", hcount, -160);
        chk("mr_vcount", vcount, TB_VRST);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mr_pe1_pix_en", pix_en, 1);
        chk("mr_pe1_hcount", hcount, -160);
        @(negedge clk);
        chk("mr_pe2_hcount", hcount, -159);
        chk("mr_pe2_mem_re", mem_re, 0);

        // End-of-run scoreboard state
        chk("no_re_we_overlap", both_seen, 0);
        chk("wr_q_empty", wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
